init_config_cw_handler: RTL and testbench
=========================================

INIT_CONFIG_CW_HANDLER -- requirements
Module: init_config_cw_handler

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: data_in  in  8  CPU data bus (D7..D0).
REQ-004 SHALL have: cs_n  in  1  chip select, active-low; wr_n  in  1  write strobe, active-low; a0  in  1  register select.
REQ-005 SHALL have: sp_n  in  1  1 = master, 0 = slave.
REQ-006 SHALL have outputs: single_mode 1, level_trigger 1, vector_base 5, slaves_connected 8, slave_id 3, aeoi 1, imr 8.
REQ-007 SHALL have outputs: ocw2_ir_level 3, ocw2_ctrl 3 ({R,SL,EOI} = D7..D5), ocw2_strobe 1, auto_rotate 1, read_type 2, ready 1.

Function
REQ-008 SHALL register wr_n each cycle and accept a write in the cycle where cs_n=0, wr_n=0 and registered wr_n=1; data_in and a0 are sampled that cycle, and the resulting outputs are visible after that clock edge.
REQ-009 SHALL ignore writes while cs_n=1; a continuously low wr_n yields exactly one accepted write.
REQ-010 SHALL use FSM states WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, OPERATIONAL.
REQ-011 ICW1 (a0=0, D4=1), accepted in any state:
- single_mode=D1, level_trigger=D3, latch IC4=D0.
- imr=0, auto_rotate=0, read_type=2'b10, ready=0, aeoi=0.
- go to WAIT_ICW2.
REQ-012 In WAIT_ICW2, a write with a0=1 SHALL set vector_base=D7..D3, then go to WAIT_ICW3 if single_mode=0, else WAIT_ICW4 if IC4=1, else OPERATIONAL.
REQ-013 In WAIT_ICW3, a write with a0=1 SHALL latch sp_n that cycle:
- sp_n=1: slaves_connected=D7..D0.
- sp_n=0: slave_id=D2..D0, slaves_connected=0.
- then go to WAIT_ICW4 if IC4=1, else OPERATIONAL.
REQ-014 In WAIT_ICW4, a write with a0=1 SHALL set aeoi=D1 and go to OPERATIONAL.
REQ-015 Writes with a0=0 and D4=0 during WAIT_ICW2..WAIT_ICW4 SHALL be ignored without a state change.
REQ-016 ready SHALL equal 1 exactly while in OPERATIONAL.
REQ-017 In OPERATIONAL, a write with a0=1 (OCW1) SHALL set imr=D7..D0.
REQ-018 In OPERATIONAL, a write with a0=0, D4=0, D3=0 (OCW2) SHALL:
- set ocw2_ctrl=D7..D5 and ocw2_ir_level=D2..D0;
- pulse ocw2_strobe high for exactly one cycle;
- ctrl 3'b100 sets auto_rotate=1, ctrl 3'b000 clears it, other codes leave it unchanged.
REQ-019 In OPERATIONAL, a write with a0=0, D4=0, D3=1 (OCW3) SHALL set read_type={1,D0} when D1=1 and leave read_type unchanged when D1=0.
REQ-020 An ICW1 during OPERATIONAL SHALL restart the sequence per REQ-011; vector_base, slaves_connected and slave_id hold their values until rewritten.

Reset
REQ-021 While rst_n=0 SHALL force:
- state=WAIT_ICW1, ready=0;
- single_mode, level_trigger, vector_base, slaves_connected, slave_id, aeoi, imr = 0;
- ocw2_ctrl, ocw2_ir_level, ocw2_strobe, auto_rotate = 0;
- read_type=2'b10, IC4 latch=0, registered wr_n=1.
REQ-022 Reset assertion mid-sequence SHALL abort the sequence; after release, only an ICW1 is accepted.

Structure
REQ-023 A shared package SHALL hold the FSM state enum and the OCW2 command constants (NS_EOI 001, SP_EOI 011, ROT_NS_EOI 101, ROT_SP_EOI 111, SET_AROT 100, CLR_AROT 000).
REQ-024 SHALL contain one sub-module, pic_wr_strobe (write-edge detector per REQ-008).
REQ-025 Priority resolution and cascade/CAS logic SHALL stay outside this block.

Verification
REQ-026 Cascaded master with ICW4:
- stimulus: sp_n=1; ICW1 0x11, ICW2 0x40, ICW3 0x04, ICW4 0x03.
- response: vector_base=5'b01000, slaves_connected=0x04, aeoi=1, ready=1 after the fourth write.
REQ-027 Single mode, no ICW4:
- stimulus: ICW1 0x1A, ICW2 0x08.
- response: single_mode=1, level_trigger=1, ready=1 after the second write, aeoi=0.
REQ-028 Slave:
- stimulus: sp_n=0; ICW1 0x11, ICW2 0x70, ICW3 0x05, ICW4 0x01.
- response: slave_id=3'b101, slaves_connected=0, ready=1.
REQ-029 OCWs when operational:
- OCW1 0xF0 -> imr=0xF0.
- OCW2 0x63 -> ocw2_ctrl=3'b011, ocw2_ir_level=3, one-cycle strobe.
- OCW2 0x80 -> auto_rotate=1.
- OCW3 0x0B -> read_type=2'b11.
REQ-030 Restart and reset:
- ICW1 while operational -> ready=0, imr=0.
- rst_n pulse between ICW2 and ICW3 -> all REQ-021 values; a following a0=1 write has no effect.

Source files
------------

// File: rtl/init_config_cw_handler_pkg.sv
// Shared types and constants for the interrupt-controller init/command word handler.
// Holds the init-sequence state enum, OCW2 command codes and the sequencing helpers.
package init_config_cw_handler_pkg;

  typedef enum logic [2:0] {
    StWaitIcw1,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StOperational
  } icw_state_e;

  // OCW2 command codes, {R, SL, EOI} = D7..D5
  localparam logic [2:0] NsEoi    = 3'b001;
  localparam logic [2:0] SpEoi    = 3'b011;
  localparam logic [2:0] RotNsEoi = 3'b101;
  localparam logic [2:0] RotSpEoi = 3'b111;
  localparam logic [2:0] SetArot  = 3'b100;
  localparam logic [2:0] ClrArot  = 3'b000;

  localparam logic [1:0] ReadTypeReset = 2'b10;

  // State following ICW2: ICW3 only exists in cascade mode, ICW4 only when IC4 was set.
  function automatic icw_state_e next_after_icw2(input logic single, input logic ic4);
    if (!single) begin
      return StWaitIcw3;
    end else if (ic4) begin
      return StWaitIcw4;
    end else begin
      return StOperational;
    end
  endfunction

  function automatic icw_state_e next_after_icw3(input logic ic4);
    return ic4 ? StWaitIcw4 : StOperational;
  endfunction

endpackage

// File: rtl/init_config_cw_handler_wr_strobe.sv
// Write-edge detector: one pulse on the first selected cycle of a low write strobe.
// A held-low wr_n produces a single pulse; deselected cycles never pulse.
module pic_wr_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic wr_n,
  output logic wr_pulse
);

  logic wr_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_n_q <= 1'b1;
    end else begin
      wr_n_q <= wr_n;
    end
  end

  assign wr_pulse = ~cs_n & ~wr_n & wr_n_q;

endmodule

// File: rtl/init_config_cw_handler.sv
// Initialization (ICW1-4) and operation (OCW1-3) command word decoder.
// Tracks the init sequence and exposes the resulting configuration as registered outputs.
module init_config_cw_handler
  import init_config_cw_handler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic       sp_n,
  output logic       single_mode,
  output logic       level_trigger,
  output logic [4:0] vector_base,
  output logic [7:0] slaves_connected,
  output logic [2:0] slave_id,
  output logic       aeoi,
  output logic [7:0] imr,
  output logic [2:0] ocw2_ir_level,
  output logic [2:0] ocw2_ctrl,
  output logic       ocw2_strobe,
  output logic       auto_rotate,
  output logic [1:0] read_type,
  output logic       ready
);

  icw_state_e state;
  icw_state_e icw2_next;
  icw_state_e icw3_next;
  logic       ic4;
  logic       wr_pulse;
  logic       is_icw1;

  pic_wr_strobe u_wr_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .wr_pulse (wr_pulse)
  );

  // ICW1 is recognised in every state and always restarts the sequence.
  assign is_icw1   = ~a0 & data_in[4];
  assign icw2_next = next_after_icw2(single_mode, ic4);
  assign icw3_next = next_after_icw3(ic4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= StWaitIcw1;
      ready            <= 1'b0;
      single_mode      <= 1'b0;
      level_trigger    <= 1'b0;
      vector_base      <= '0;
      slaves_connected <= '0;
      slave_id         <= '0;
      aeoi             <= 1'b0;
      imr              <= '0;
      ocw2_ctrl        <= '0;
      ocw2_ir_level    <= '0;
      ocw2_strobe      <= 1'b0;
      auto_rotate      <= 1'b0;
      read_type        <= ReadTypeReset;
      ic4              <= 1'b0;
    end else begin
      ocw2_strobe <= 1'b0;
      if (wr_pulse) begin
        if (is_icw1) begin
          single_mode   <= data_in[1];
          level_trigger <= data_in[3];
          ic4           <= data_in[0];
          imr           <= '0;
          auto_rotate   <= 1'b0;
          read_type     <= ReadTypeReset;
          ready         <= 1'b0;
          aeoi          <= 1'b0;
          state         <= StWaitIcw2;
        end else begin
          unique case (state)
            StWaitIcw1: ;
            StWaitIcw2: begin
              if (a0) begin
                vector_base <= data_in[7:3];
                state       <= icw2_next;
                ready       <= (icw2_next == StOperational);
              end
            end
            StWaitIcw3: begin
              if (a0) begin
                if (sp_n) begin
                  slaves_connected <= data_in;
                end else begin
                  slave_id         <= data_in[2:0];
                  slaves_connected <= '0;
                end
                state <= icw3_next;
                ready <= (icw3_next == StOperational);
              end
            end
            StWaitIcw4: begin
              if (a0) begin
                aeoi  <= data_in[1];
                state <= StOperational;
                ready <= 1'b1;
              end
            end
            StOperational: begin
              if (a0) begin
                imr <= data_in;
              end else if (!data_in[3]) begin
                ocw2_ctrl     <= data_in[7:5];
                ocw2_ir_level <= data_in[2:0];
                ocw2_strobe   <= 1'b1;
                if (data_in[7:5] == SetArot) begin
                  auto_rotate <= 1'b1;
                end else if (data_in[7:5] == ClrArot) begin
                  auto_rotate <= 1'b0;
                end
              end else if (data_in[1]) begin
                read_type <= {1'b1, data_in[0]};
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_init_config_cw_handler.sv
// Directed and randomized bench for init_config_cw_handler against a sequence-list model.
// The model keeps the pending init words as a queue derived from ICW1.
module tb_init_config_cw_handler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic       sp_n;
  logic       single_mode;
  logic       level_trigger;
  logic [4:0] vector_base;
  logic [7:0] slaves_connected;
  logic [2:0] slave_id;
  logic       aeoi;
  logic [7:0] imr;
  logic [2:0] ocw2_ir_level;
  logic [2:0] ocw2_ctrl;
  logic       ocw2_strobe;
  logic       auto_rotate;
  logic [1:0] read_type;
  logic       ready;

  int tests = 0;
  int fails = 0;

  init_config_cw_handler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in          (data_in),
    .cs_n             (cs_n),
    .wr_n             (wr_n),
    .a0               (a0),
    .sp_n             (sp_n),
    .single_mode      (single_mode),
    .level_trigger    (level_trigger),
    .vector_base      (vector_base),
    .slaves_connected (slaves_connected),
    .slave_id         (slave_id),
    .aeoi             (aeoi),
    .imr              (imr),
    .ocw2_ir_level    (ocw2_ir_level),
    .ocw2_ctrl        (ocw2_ctrl),
    .ocw2_strobe      (ocw2_strobe),
    .auto_rotate      (auto_rotate),
    .read_type        (read_type),
    .ready            (ready)
  );

  always #5 clk = ~clk;

  // Reference model: configuration values plus the list of init words still expected.
  logic       m_single, m_level, m_aeoi, m_arot, m_strobe, m_init;
  logic [4:0] m_vb;
  logic [7:0] m_slaves, m_imr;
  logic [2:0] m_sid, m_ctrl, m_lvl;
  logic [1:0] m_rt;
  int         pend[$];

  task automatic model_reset();
    m_single = 0; m_level = 0; m_aeoi = 0; m_arot = 0; m_strobe = 0; m_init = 0;
    m_vb = 0; m_slaves = 0; m_imr = 0; m_sid = 0; m_ctrl = 0; m_lvl = 0;
    m_rt = 2'b10;
    pend.delete();
  endtask

  task automatic model_write(input logic a, input logic [7:0] d, input logic s);
    int step;
    m_strobe = 0;
    if (!a && d[4]) begin
      m_single = d[1]; m_level = d[3]; m_imr = 0; m_arot = 0; m_rt = 2'b10; m_aeoi = 0;
      m_init = 1;
      pend.delete();
      pend.push_back(2);
      if (!d[1]) pend.push_back(3);
      if (d[0]) pend.push_back(4);
    end else if (m_init && pend.size() > 0) begin
      if (a) begin
        step = pend.pop_front();
        if (step == 2) m_vb = d[7:3];
        else if (step == 3) begin
          if (s) m_slaves = d;
          else begin m_sid = d[2:0]; m_slaves = 0; end
        end else m_aeoi = d[1];
      end
    end else if (m_init) begin
      if (a) m_imr = d;
      else if (!d[3]) begin
        m_ctrl = d[7:5]; m_lvl = d[2:0]; m_strobe = 1;
        if (d[7:5] == 3'b100) m_arot = 1;
        else if (d[7:5] == 3'b000) m_arot = 0;
      end else if (d[1]) m_rt = {1'b1, d[0]};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".single_mode"}, 32'(single_mode), 32'(m_single));
    chk({tag, ".level_trigger"}, 32'(level_trigger), 32'(m_level));
    chk({tag, ".vector_base"}, 32'(vector_base), 32'(m_vb));
    chk({tag, ".slaves_connected"}, 32'(slaves_connected), 32'(m_slaves));
    chk({tag, ".slave_id"}, 32'(slave_id), 32'(m_sid));
    chk({tag, ".aeoi"}, 32'(aeoi), 32'(m_aeoi));
    chk({tag, ".imr"}, 32'(imr), 32'(m_imr));
    chk({tag, ".ocw2_ctrl"}, 32'(ocw2_ctrl), 32'(m_ctrl));
    chk({tag, ".ocw2_ir_level"}, 32'(ocw2_ir_level), 32'(m_lvl));
    chk({tag, ".ocw2_strobe"}, 32'(ocw2_strobe), 32'(m_strobe));
    chk({tag, ".auto_rotate"}, 32'(auto_rotate), 32'(m_arot));
    chk({tag, ".read_type"}, 32'(read_type), 32'(m_rt));
    chk({tag, ".ready"}, 32'(ready), 32'(m_init && pend.size() == 0));
  endtask

  // One complete bus write: strobe low for one cycle, then released for one cycle.
  task automatic wr(input string tag, input logic a, input logic [7:0] d, input logic s);
    @(negedge clk);
    a0 = a; data_in = d; sp_n = s; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    model_write(a, d, s);
    check_all(tag);
    cs_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    m_strobe = 0;
    chk({tag, ".strobe_drop"}, 32'(ocw2_strobe), 32'd0);
  endtask

  initial begin
    logic       ra, rs;
    logic [7:0] rd;
    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; data_in = 8'h00; sp_n = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Before any ICW1, a0=1 writes do nothing
    wr("pre_icw1", 1'b1, 8'hFF, 1'b1);

    // Cascaded master with ICW4
    wr("m_icw1", 1'b0, 8'h11, 1'b1);
    wr("m_icw2", 1'b1, 8'h40, 1'b1);
    chk("m_notready3", 32'(ready), 32'd0);
    wr("m_icw3", 1'b1, 8'h04, 1'b1);
    wr("m_icw4", 1'b1, 8'h03, 1'b1);
    chk("m_vb_const", 32'(vector_base), 32'h08);
    chk("m_slaves_const", 32'(slaves_connected), 32'h04);
    chk("m_aeoi_const", 32'(aeoi), 32'd1);
    chk("m_ready_const", 32'(ready), 32'd1);

    // OCWs while operational
    wr("ocw1", 1'b1, 8'hF0, 1'b1);
    chk("ocw1_const", 32'(imr), 32'hF0);
    wr("ocw2_63", 1'b0, 8'h63, 1'b1);
    wr("ocw2_80", 1'b0, 8'h80, 1'b1);
    chk("arot_const", 32'(auto_rotate), 32'd1);
    wr("ocw2_e1", 1'b0, 8'hE1, 1'b1);
    wr("ocw3_0b", 1'b0, 8'h0B, 1'b1);
    chk("rt_const", 32'(read_type), 32'h3);
    wr("ocw3_08", 1'b0, 8'h08, 1'b1);
    wr("ocw2_00", 1'b0, 8'h00, 1'b1);

    // Deselected write is ignored
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b0; a0 = 1'b1; data_in = 8'h33;
    @(posedge clk); #1; check_all("cs_high");
    @(negedge clk); wr_n = 1'b1;

    // Held-low strobe is accepted once, data changes afterwards are ignored
    @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_in = 8'h5A;
    @(posedge clk); #1; model_write(1'b1, 8'h5A, 1'b1); check_all("hold_first");
    @(negedge clk); data_in = 8'hA5;
    repeat (3) @(posedge clk);
    #1; check_all("hold_later");
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;

    // Single mode, no ICW4; configuration registers persist
    wr("s_icw1", 1'b0, 8'h1A, 1'b1);
    chk("s_ready0", 32'(ready), 32'd0);
    wr("s_icw2", 1'b1, 8'h08, 1'b1);

    // Slave
    wr("sl_icw1", 1'b0, 8'h11, 1'b0);
    wr("sl_bad", 1'b0, 8'h05, 1'b0);
    wr("sl_icw2", 1'b1, 8'h70, 1'b0);
    wr("sl_icw3", 1'b1, 8'h05, 1'b0);
    wr("sl_icw4", 1'b1, 8'h01, 1'b0);
    chk("sl_sid_const", 32'(slave_id), 32'h5);

    // Asynchronous reset between ICW2 and ICW3
    wr("r_ocw1", 1'b1, 8'h3C, 1'b1);
    wr("r_icw1", 1'b0, 8'h10, 1'b1);
    wr("r_icw2", 1'b1, 8'hA8, 1'b1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1; model_reset(); check_all("r_async");
    @(negedge clk) rst_n = 1'b1;
    wr("r_after", 1'b1, 8'hFF, 1'b1);

    // Randomized writes; ICW1 kept rare so operational commands get exercised
    for (int i = 0; i < 400; i++) begin
      ra = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      if (!ra && $urandom_range(0, 7) != 0) rd[4] = 1'b0;
      wr("rand", ra, rd, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
